instr_mem_loader: RTL

Boot-time writer for the instruction memory. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word into a writable instruction memory. It holds the pipeline core in reset until a complete image has been loaded and, when enabled, checksum-verified. It sits between the host/debug byte link and the instruction memory write port; the fetch stage reads the same memory afterwards.

---
 rtl/instr_mem_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot-time byte-stream loader for the instruction memory (optional checksum: LOADER_CHECKSUM_EN)
module instr_mem_loader #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_HDR0  = 3'd0,
      S_HDR1  = 3'd1,
      S_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK = 3'd3,
`endif
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   // State entered once the payload is exhausted (or for an empty image).
`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHECK;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t      state, nxt;
   logic [15:0] count;
   logic [15:0] words_done;
   logic [1:0]  lane;
   logic [23:0] word_buf;
   logic [7:0]  csum;
   logic        accept;
   logic        last_word;
   logic        restart;
   logic        done_nxt;
   logic [15:0] hdr_count;

   assign byte_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                       || (state == S_CHECK)
`endif
                       ;
   assign accept    = byte_valid && byte_ready;
   assign hdr_count = {byte_data, count[7:0]};
   assign last_word = ((words_done + 16'd1) == count);
   assign restart   = start && ((state == S_DONE) || (state == S_ERROR));
   // Done rises with the transition out of HDR1/CHECK, but one cycle after the
   // last write when leaving DATA, so the final write completes first.
   assign done_nxt  = (nxt == S_DONE) && (state != S_DATA);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_HDR0;
      else       state <= nxt;
   end

   // Next-state decode from the accepted byte and the word bookkeeping.
   always_comb begin
      nxt = state;
      case (state)
         S_HDR0: if (accept) nxt = S_HDR1;
         S_HDR1: begin
            if (accept) begin
               if ({1'b0, hdr_count} > DEPTH_W) nxt = S_ERROR;
               else if (hdr_count == 16'd0)     nxt = S_TAIL;
               else                             nxt = S_DATA;
            end
         end
         S_DATA: if (accept && (lane == 2'd3) && last_word) nxt = S_TAIL;
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: if (accept) nxt = (byte_data == csum) ? S_DONE : S_ERROR;
`endif
         S_DONE:  if (start) nxt = S_HDR0;
         S_ERROR: if (start) nxt = S_HDR0;
         default: nxt = S_HDR0;
      endcase
   end

   // Header capture, word assembly, write strobe and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= 16'd0;
         words_done <= 16'd0;
         lane       <= 2'd0;
         word_buf   <= 24'd0;
         csum       <= 8'd0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'd0;
         done       <= 1'b0;
         error      <= 1'b0;
         core_hold  <= 1'b1;
      end else begin
         imem_we   <= 1'b0;
         done      <= done_nxt;
         error     <= (nxt == S_ERROR);
         core_hold <= !done_nxt;
         if (imem_we) imem_addr <= imem_addr + 32'd4;
         if (accept) begin
            case (state)
               S_HDR0: count[7:0]  <= byte_data;
               S_HDR1: count[15:8] <= byte_data;
               S_DATA: begin
                  csum <= csum + byte_data;
                  lane <= lane + 2'd1;
                  if (lane == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_wdata <= {byte_data, word_buf};
                     words_done <= words_done + 16'd1;
                  end else begin
                     word_buf[8*lane +: 8] <= byte_data;
                  end
               end
               default: ;
            endcase
         end
         if (restart) begin
            imem_addr  <= BASE_ADDR;
            csum       <= 8'd0;
            lane       <= 2'd0;
            count      <= 16'd0;
            words_done <= 16'd0;
         end
      end
   end

endmodule
